// File: rtl/riscv151_csr_pkg.sv
// Shared CSR definitions for the Riscv151 CSR unit: addresses, op encodings,
// request bundle and the read-modify-write helper.
package riscv151_csr_pkg;

  localparam int CSR_W = 32;

  localparam logic [11:0] CSR_TOHOST   = 12'h51E;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_e;

  typedef struct packed {
    logic             valid;
    csr_op_e          op;
    logic [11:0]      addr;
    logic [CSR_W-1:0] wdata;
    logic             src_zero;
  } csr_req_t;

  function automatic logic [CSR_W-1:0] csr_apply(input csr_op_e op,
                                                 input logic [CSR_W-1:0] old,
                                                 input logic [CSR_W-1:0] wdata);
    case (op)
      CSR_OP_RW: csr_apply = wdata;
      CSR_OP_RS: csr_apply = old | wdata;
      CSR_OP_RC: csr_apply = old & ~wdata;
      default:   csr_apply = old;
    endcase
  endfunction

endpackage

// File: rtl/riscv151_csr_unit_counter64.sv
// 64-bit free-running counter with enable; one adder so the carry into the
// high half lands in the same cycle as the low half wraps.
module csr_counter64
  import riscv151_csr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CSR_W-1:0] lo,
  output logic [CSR_W-1:0] hi
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign lo = cnt_q[31:0];
  assign hi = cnt_q[63:32];

endmodule

// File: rtl/riscv151_csr_unit.sv
// CSR unit: executes CSR ops from execute, holds tohost behind a one-entry
// pending stage, and keeps the cycle/instret counters.
module riscv151_csr_unit
  import riscv151_csr_pkg::*;
#(
  parameter logic [CSR_W-1:0] RESET_TOHOST = 32'h0000_0000,
  parameter logic [11:0]      TOHOST_ADDR  = CSR_TOHOST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [11:0]      req_addr,
  input  logic [CSR_W-1:0] req_wdata,
  input  logic             req_src_zero,
  input  logic             stall,
  input  logic             retire,
  output logic [CSR_W-1:0] rdata,
  output logic             illegal,
  output logic [CSR_W-1:0] csr
);

  csr_req_t         req;
  logic [CSR_W-1:0] cycle_lo, cycle_hi, instret_lo, instret_hi;
  logic [CSR_W-1:0] tohost_q, tohost_d, pend_data_q, pend_data_d, old_val;
  logic             pend_valid_q, pend_valid_d, done_q, done_d;
  logic             mapped, ro, wr_en, active, commit, capture, drain;

  assign req = '{valid: req_valid, op: csr_op_e'(req_op), addr: req_addr,
                 wdata: req_wdata, src_zero: req_src_zero};

  csr_counter64 u_cycle (
    .clk(clk), .rst_n(rst), .en(1'b1), .lo(cycle_lo), .hi(cycle_hi)
  );

  csr_counter64 u_instret (
    .clk(clk), .rst_n(rst), .en(retire), .lo(instret_lo), .hi(instret_hi)
  );

  always_comb begin
    mapped  = 1'b1;
    ro      = 1'b1;
    old_val = '0;
    case (req.addr)
      // In-flight tohost write is forwarded so back-to-back RMW sees it.
      TOHOST_ADDR: begin
        ro      = 1'b0;
        old_val = pend_valid_q ? pend_data_q : tohost_q;
      end
      CSR_CYCLE:    old_val = cycle_lo;
      CSR_CYCLEH:   old_val = cycle_hi;
      CSR_INSTRET:  old_val = instret_lo;
      CSR_INSTRETH: old_val = instret_hi;
      default:      mapped  = 1'b0;
    endcase
    wr_en   = (req.op == CSR_OP_RW) || !req.src_zero;
    active  = req.valid && (req.op != CSR_OP_NONE);
    illegal = active && (!mapped || (wr_en && ro));
    commit  = active && !stall && !illegal;
    capture = commit && wr_en && !ro && !done_q;
  end

  assign rdata = old_val;

  always_comb begin
    pend_valid_d = capture;
    pend_data_d  = pend_data_q;
    if (capture) pend_data_d = csr_apply(req.op, old_val, req.wdata);
    // Once done, the frozen pass/fail code must not be overwritten even by
    // a write that was already in flight.
    drain    = pend_valid_q && !done_q;
    tohost_d = drain ? pend_data_q : tohost_q;
    done_d   = done_q || (drain && pend_data_q[0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tohost_q     <= RESET_TOHOST;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      tohost_q     <= tohost_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      done_q       <= done_d;
    end
  end

  assign csr = tohost_q;

endmodule

// File: tb/tb_riscv151_csr_unit.sv
// Directed bench for riscv151_csr_unit: reset, tohost pipeline, forwarding,
// stall, sticky done, illegal detection and counter wrap.
module tb_riscv151_csr_unit;

  logic        clk, rst, req_valid, req_src_zero, stall, retire, illegal;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata, rdata, csr;
  int          n_chk, n_pass;

  localparam logic [1:0] OP_NONE = 2'd0, OP_RW = 2'd1, OP_RS = 2'd2;

  riscv151_csr_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_src_zero(req_src_zero),
    .stall(stall), .retire(retire), .rdata(rdata), .illegal(illegal),
    .csr(csr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input logic sz);
    req_valid = v; req_op = op; req_addr = a; req_wdata = wd; req_src_zero = sz;
  endtask

  task automatic idle();
    drive(1'b0, OP_NONE, 12'h000, 32'h0, 1'b1);
    stall = 1'b0; retire = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    drive(1'b1, OP_RS, a, 32'h0, 1'b1);
    #1;
  endtask

  // Returns on the negedge where reset is released.
  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    clk = 1'b0; rst = 1'b0;
    idle();

    // reset and cycle counting
    repeat (5) begin
      @(negedge clk);
      rd(12'hC00);
      chk("rst_csr", csr, 32'h0);
      chk("rst_cycle", rdata, 32'h0);
    end
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      rd(12'hC00);
      chk($sformatf("cycle_%0d", i), rdata, i);
    end
    rd(12'hC02);
    chk("instret_idle", rdata, 32'h0);

    // tohost write, then sticky done
    @(negedge clk);
    drive(1'b1, OP_RW, 12'h51E, 32'h1, 1'b0);
    #1;
    chk("th_rdata", rdata, 32'h0);
    chk("th_legal", illegal, 1'b0);
    @(negedge clk); idle(); #1;
    chk("th_edge1", csr, 32'h0);
    @(negedge clk); #1;
    chk("th_edge2", csr, 32'h1);
    drive(1'b1, OP_RW, 12'h51E, 32'h5, 1'b0);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    #1;
    chk("sticky_csr", csr, 32'h1);
    rd(12'h51E);
    chk("sticky_rd", rdata, 32'h1);

    // fail code with forwarding
    do_reset();
    drive(1'b1, OP_RW, 12'h51E, 32'h6, 1'b0);
    @(negedge clk);
    drive(1'b1, OP_RS, 12'h51E, 32'h1, 1'b0);
    #1;
    chk("fwd_rdata", rdata, 32'h6);
    @(negedge clk); idle(); #1;
    chk("fwd_mid", csr, 32'h6);
    @(negedge clk); #1;
    chk("fwd_csr", csr, 32'h7);
    drive(1'b1, OP_RW, 12'h51E, 32'h0, 1'b0);
    @(negedge clk); idle();
    repeat (2) @(negedge clk);
    #1;
    chk("fwd_sticky", csr, 32'h7);

    // stall blocks capture
    do_reset();
    drive(1'b1, OP_RW, 12'h51E, 32'hA, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("stall_%0d", i), csr, 32'h0);
    end
    stall = 1'b0;
    @(negedge clk); idle(); #1;
    chk("stall_e1", csr, 32'h0);
    @(negedge clk); #1;
    chk("stall_e2", csr, 32'hA);

    // reset discards pending write
    drive(1'b1, OP_RW, 12'h51E, 32'h3, 1'b0);
    @(negedge clk); idle();
    rst = 1'b0;
    #1;
    chk("rst_async", csr, 32'h0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_discard", csr, 32'h0);

    // illegal accesses
    do_reset();
    drive(1'b1, OP_RW, 12'hC00, 32'h0001_2345, 1'b0);
    #1;
    chk("ill_rw_ro", illegal, 1'b1);
    chk("ill_rw_rd", rdata, 32'h0);
    @(negedge clk);
    rd(12'hC00);
    chk("ro_read_legal", illegal, 1'b0);
    chk("ro_cycle", rdata, 32'h1);
    drive(1'b1, OP_RS, 12'hC00, 32'h4, 1'b0);
    #1;
    chk("ill_rs_ro", illegal, 1'b1);
    rd(12'h123);
    chk("ill_unmap", illegal, 1'b1);
    chk("unmap_rdata", rdata, 32'h0);
    drive(1'b1, OP_NONE, 12'h123, 32'h0, 1'b0);
    #1;
    chk("nop_legal", illegal, 1'b0);
    drive(1'b0, OP_RW, 12'h123, 32'h0, 1'b0);
    #1;
    chk("novalid_legal", illegal, 1'b0);
    idle();

    // instret wrap
    @(negedge clk);
    force dut.u_instret.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_instret.cnt_q;
    retire = 1'b1;
    rd(12'hC02);
    chk("ret_old", rdata, 32'hFFFF_FFFF);
    @(negedge clk); retire = 1'b0;
    rd(12'hC02);
    chk("wrap_lo", rdata, 32'h0);
    rd(12'hC82);
    chk("wrap_hi", rdata, 32'h1);
    force dut.u_instret.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_instret.cnt_q;
    retire = 1'b1;
    @(negedge clk); retire = 1'b0;
    rd(12'hC02);
    chk("wrap64_lo", rdata, 32'h0);
    rd(12'hC82);
    chk("wrap64_hi", rdata, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv151_csr_unit.md
# riscv151_csr_unit

Control/status register unit for the Riscv151 core: executes CSR instructions from the execute stage and drives the 32-bit `csr` (tohost) output that the ISA bench polls for pass/fail. It also keeps the 64-bit cycle and instret counters. It sits beside the ALU, and its read data muxes into the writeback path.

## Interface
- `RESET_TOHOST`, 32'h0000_0000, reset value of tohost.
- `TOHOST_ADDR`, 12'h51E, CSR address of tohost.
- `clk`  input  1  core clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  a CSR instruction is in execute this cycle.
- `req_op`  input  2  1=RW, 2=RS, 3=RC; 0 means no-op and is never illegal.
- `req_addr`  input  12  CSR address.
- `req_wdata`  input  32  rs1 value, or the zero-extended 5-bit immediate.
- `req_src_zero`  input  1  rs1 field (or immediate) is zero.
- `stall`  input  1  execute is held; the request must not commit.
- `retire`  input  1  one instruction retires this cycle.
- `rdata`  output  32  old CSR value, combinational from the request inputs.
- `illegal`  output  1  combinational; see Operation.
- `csr`  output  32  registered copy of tohost.

## Operation
- Registers:
  - tohost, 0x51E, RW.
  - cycle, 0xC00, read-only: low half of the 64-bit cycle counter. cycleh, 0xC80, read-only: high half.
  - instret, 0xC02, read-only: low half of the 64-bit instret counter. instreth, 0xC82, read-only: high half.
- Commit condition is `req_valid && !stall && op!=0`.
- New value on commit:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
- Write suppression: RS/RC with `req_src_zero`=1 are read-only accesses. They write nothing and are legal on read-only CSRs. RW always writes.
- `illegal`=1 if the request is valid with op!=0 and either:
  - the address is unmapped, in which case `rdata`=0; or
  - the access is a non-suppressed write to a read-only CSR.
- An illegal request changes no state.
- Write pipeline: a tohost commit is captured into a pending register (`pend_valid`, `pend_data`). Pending data lands in tohost/`csr` on the next rising edge.
- Forwarding: a read of tohost while `pend_valid`=1 returns `pend_data`. A read-modify-write in back-to-back cycles therefore sees its predecessor's result.
- cycle counter:
  - Increments every clock once reset is released, including stalled cycles.
  - Wraps from 2^64-1 to 0; the carry crosses the halves in the same cycle.
- instret counter:
  - Increments when `retire`=1.
  - Wraps the same way as cycle.
- Counter reads in a given cycle return the value before that edge's increment.
- Sticky done: once a committed value with bit 0 set reaches `csr`, later tohost writes are ignored until reset. This freezes the pass/fail code.

## Timing
- Reset values while `rst`=0, asynchronously:
  - cycle, instret and `pend_valid` are 0, and done is clear.
  - `csr` and tohost are `RESET_TOHOST`.
- `rdata` and `illegal` are combinational and follow the inputs during reset as well.
- Latency:
  - `rdata` and `illegal` are available in the same cycle as the request.
  - `csr` updates 2 edges after the commit cycle: edge 1 loads pending, edge 2 loads tohost.
- `stall`=1 blocks capture into pending. An already-pending write still drains; draining never stalls.
- Simultaneous events:
  - Pending drain plus a new tohost commit: the drain lands, and the new value enters pending.
  - Retire together with an instret read: the read returns the old value.
- Reset asserted mid-operation discards the pending write immediately.

## Structure
- Shared package `riscv151_csr_pkg` holds:
  - CSR address constants: tohost, cycle, cycleh, instret, instreth.
  - op encodings for none, RW, RS, RC.
  - `CSR_W` = 32.
- Sub-module `csr_counter64`: 64-bit counter with enable, async active-low reset, hi/lo read ports. It is instantiated twice (cycle, instret).

## Test plan
- Reset: hold `rst`=0 for 5 cycles, then release.
  - During reset: `csr`=0, and cycle read = 0.
  - After release: cycle reads 1, 2, 3 on successive edges.
- Tohost write: CSRRW tohost with wdata=32'h1.
  - `rdata`=0 in the request cycle.
  - `csr`=1 after 2 edges; a subsequent RW of 32'h5 leaves `csr`=1 (sticky).
- Fail code and forwarding:
  - CSRRW tohost 32'h6; next cycle CSRRS tohost 32'h1.
  - The second request's `rdata`=6 (forwarded), and finally `csr`=32'h7.
- Stall: CSRRW tohost 32'hA with `stall`=1 for 3 cycles, then 0.
  - `csr` unchanged during the stall.
  - `csr`=32'hA two edges after the stall drops.
- Illegal access:
  - CSRRW to 0xC00 → `illegal`=1, cycle unaffected.
  - CSRRS to 0xC00 with `req_src_zero`=1 → `illegal`=0.
  - Read of 0x123 → `illegal`=1, `rdata`=0.
- Counter wrap: force instret to 64'h0000_0000_FFFF_FFFF and pulse `retire`.
  - instret reads 0 and instreth reads 1.
  - Force 2^64-1 and retire → both halves read 0.
